// File: rtl/load_store_unit_if.sv
// Pipeline request/response and data-memory bus bundle for load_store_unit.
// master = the LSU side, slave = pipeline/memory environment side.
interface load_store_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_error;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/load_store_unit.sv
// RISC-V load/store unit: word-aligned memory transactions with byte enables and load extension.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned/unsupported accesses complete with an error, no bus cycle.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic               clk,
    input  logic               rst,
    load_store_unit_if.master  bus
);

    localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TMO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

    state_e            state_q,     state_d;
    logic [2:0]        funct3_q,    funct3_d;
    logic [1:0]        lo_q,        lo_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q,    mem_be_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_error_q, rsp_error_d;
    logic [CNT_W-1:0]  tmo_cnt_q,   tmo_cnt_d;

    logic [1:0]  req_lo_c;
    logic [3:0]  fmt_be_c;
    logic [31:0] fmt_wdata_c;
    logic        misalign_c;
    logic [31:0] shifted_c;
    logic [15:0] half_c;
    logic [31:0] load_c;

    assign req_lo_c = bus.req_addr[1:0];

    // Store lane formatting: size comes from funct3[1:0], 11/10 behave as a word
    always_comb begin
        fmt_be_c    = 4'b1111;
        fmt_wdata_c = bus.req_wdata;
        case (bus.req_funct3[1:0])
            2'b00: begin
                fmt_be_c    = 4'(4'b0001 << req_lo_c);
                fmt_wdata_c = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                fmt_be_c    = req_lo_c[1] ? 4'b1100 : 4'b0011;
                fmt_wdata_c = {2{bus.req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        misalign_c = 1'b0;
        case (bus.req_funct3)
            3'b001, 3'b101:         misalign_c = req_lo_c[0];
            3'b010:                 misalign_c = (req_lo_c != 2'b00);
            3'b011, 3'b110, 3'b111: misalign_c = 1'b1;
            default:                misalign_c = 1'b0;
        endcase
    end
`else
    assign misalign_c = 1'b0;
`endif

    // Load extraction from the captured lane offset and funct3
    assign shifted_c = bus.mem_rdata >> {lo_q, 3'b000};
    assign half_c    = lo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    always_comb begin
        load_c = bus.mem_rdata;
        case (funct3_q[1:0])
            2'b00:   load_c = funct3_q[2] ? {24'b0, shifted_c[7:0]}
                                          : {{24{shifted_c[7]}}, shifted_c[7:0]};
            2'b01:   load_c = funct3_q[2] ? {16'b0, half_c}
                                          : {{16{half_c[15]}}, half_c};
            default: load_c = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        funct3_d    = funct3_q;
        lo_d        = lo_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        tmo_cnt_d   = tmo_cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    funct3_d    = bus.req_funct3;
                    lo_d        = req_lo_c;
                    mem_we_d    = bus.req_write;
                    mem_addr_d  = {bus.req_addr[ADDR_W-1:2], 2'b00};
                    mem_be_d    = bus.req_write ? fmt_be_c : 4'b1111;
                    mem_wdata_d = fmt_wdata_c;
                    tmo_cnt_d   = '0;
                    if (misalign_c) begin
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                        rsp_rdata_d = '0;
                        state_d     = RESP;
                    end else begin
                        mem_req_d = 1'b1;
                        state_d   = BUS;
                    end
                end
            end
            BUS: begin
                if (bus.mem_ack) begin
                    mem_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b0;
                    rsp_rdata_d = mem_we_q ? 32'b0 : load_c;
                    state_d     = RESP;
                end else if ((TIMEOUT_CYCLES != 0) && (tmo_cnt_q == CNT_W'(TMO_LAST))) begin
                    mem_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            funct3_q    <= '0;
            lo_q        <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            funct3_q    <= funct3_d;
            lo_q        <= lo_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_error = rsp_error_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;

endmodule
